count_window_monitor: RTL and testbench

Downstream consumer of the 8-bit up/down counter. Samples the counter's count, load and mode every clock and classifies count against a programmable [lo,hi] window. Detects genuine wrap-around in either direction, ignoring jumps caused by load, and measures dwell time inside the window. Raises a maskable, sticky, acknowledgeable interrupt for the control logic.

---
 rtl/count_mon_pkg.sv | 26 ++
 rtl/count_wrap_detector.sv | 60 ++++++
 rtl/count_window_monitor.sv | 132 +++++++++++++
 tb/tb_count_window_monitor.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/count_mon_pkg.sv
// Shared encodings for the count window monitor: zone codes, status bit
// positions and the window state machine enum.
package count_mon_pkg;

    // Zone codes presented on the zone output
    localparam logic [1:0] ZONE_NONE   = 2'b00;
    localparam logic [1:0] ZONE_BELOW  = 2'b01;
    localparam logic [1:0] ZONE_INSIDE = 2'b10;
    localparam logic [1:0] ZONE_ABOVE  = 2'b11;

    // Bit positions inside the sticky status vector
    localparam int ST_WRAP   = 0;
    localparam int ST_ENTER  = 1;
    localparam int ST_EXIT   = 2;
    localparam int ST_CFGERR = 3;

    // State encoding matches the zone codes, so the state register drives
    // the zone output directly and IDLE reads as NONE.
    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_BELOW  = 2'b01,
        S_INSIDE = 2'b10,
        S_ABOVE  = 2'b11
    } mon_state_t;

endpackage

// File: rtl/count_wrap_detector.sv
// Wrap-around detector: remembers the previous sample, its direction and
// whether the current sample is a loaded value, and flags genuine MAX->0
// (up) or 0->MAX (down) steps. Loaded jumps never count as a wrap.
module count_wrap_detector #(
    parameter int WIDTH = 8
) (
    input  logic             i_clock,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_count,
    input  logic             i_load,
    input  logic             i_mode,
    output logic             o_wrap_up,
    output logic             o_wrap_dn,
    output logic             o_wrap_evt
);

    localparam logic [WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [WIDTH-1:0] CNT_ZERO = '0;

    logic [WIDTH-1:0] r_prev;
    logic             r_prev_valid;
    logic             r_load_q;
    logic             r_mode_q;
    logic             r_wrap_up;
    logic             r_wrap_dn;
    logic             w_wrap_up;
    logic             w_wrap_dn;

    // A wrap needs a previous sample that survived reset and a current
    // sample that is not the result of a load.
    assign w_wrap_up = r_prev_valid && !r_load_q && r_mode_q &&
                       (r_prev == CNT_MAX) && (i_count == CNT_ZERO);
    assign w_wrap_dn = r_prev_valid && !r_load_q && !r_mode_q &&
                       (r_prev == CNT_ZERO) && (i_count == CNT_MAX);

    // Capture sample history and register the one-cycle wrap pulses
    always_ff @(posedge i_clock) begin
        if (i_clear) begin
            r_prev       <= '0;
            r_prev_valid <= 1'b0;
            r_load_q     <= 1'b0;
            r_mode_q     <= 1'b0;
            r_wrap_up    <= 1'b0;
            r_wrap_dn    <= 1'b0;
        end else begin
            r_prev       <= i_count;
            r_prev_valid <= 1'b1;
            r_load_q     <= i_load;
            r_mode_q     <= i_mode;
            r_wrap_up    <= w_wrap_up;
            r_wrap_dn    <= w_wrap_dn;
        end
    end

    assign o_wrap_up  = r_wrap_up;
    assign o_wrap_dn  = r_wrap_dn;
    // Unregistered event so the status bit lands in the same cycle as the pulse
    assign o_wrap_evt = w_wrap_up | w_wrap_dn;

endmodule

// File: rtl/count_window_monitor.sv
// Count window monitor: classifies each counter sample against a
// programmable [lo,hi] window, tracks dwell time inside it, reports wraps
// and raises a maskable sticky interrupt.
module count_window_monitor
    import count_mon_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int DWELL_W = 16
) (
    input  logic               clock,
    input  logic               clear,
    input  logic [WIDTH-1:0]   count_in,
    input  logic               load_in,
    input  logic               mode_in,
    input  logic               cfg_we,
    input  logic [WIDTH-1:0]   lo_in,
    input  logic [WIDTH-1:0]   hi_in,
    input  logic [3:0]         irq_en,
    input  logic [3:0]         irq_ack,
    output logic [1:0]         zone,
    output logic               wrap_up,
    output logic               wrap_dn,
    output logic [DWELL_W-1:0] dwell,
    output logic [3:0]         status,
    output logic               irq
);

    localparam logic [DWELL_W-1:0] DWELL_MAX = '1;
    localparam logic [DWELL_W-1:0] DWELL_ONE = {{(DWELL_W-1){1'b0}}, 1'b1};

    mon_state_t         r_state;
    mon_state_t         w_next_state;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_hi;
    logic [DWELL_W-1:0] r_dwell;
    logic [DWELL_W-1:0] w_next_dwell;
    logic [3:0]         r_status;
    logic [3:0]         w_set;
    logic               r_irq;
    logic               w_enter;
    logic               w_exit;
    logic               w_wrap_evt;
    logic               w_cfg_ok;
    logic               w_cfg_bad;

    count_wrap_detector #(
        .WIDTH (WIDTH)
    ) u_wrap (
        .i_clock    (clock),
        .i_clear    (clear),
        .i_count    (count_in),
        .i_load     (load_in),
        .i_mode     (mode_in),
        .o_wrap_up  (wrap_up),
        .o_wrap_dn  (wrap_dn),
        .o_wrap_evt (w_wrap_evt)
    );

    assign w_cfg_ok  = cfg_we && (lo_in <= hi_in);
    assign w_cfg_bad = cfg_we && (lo_in > hi_in);

    // Next state is the zone of the current sample; enter/exit only fire
    // between real zones, never out of IDLE.
    always_comb begin
        w_next_state = r_state;
        w_enter      = 1'b0;
        w_exit       = 1'b0;
        if (count_in < r_lo) begin
            w_next_state = S_BELOW;
        end else if (count_in > r_hi) begin
            w_next_state = S_ABOVE;
        end else begin
            w_next_state = S_INSIDE;
        end
        case (r_state)
            S_BELOW, S_ABOVE: w_enter = (w_next_state == S_INSIDE);
            S_INSIDE:         w_exit  = (w_next_state != S_INSIDE);
            default:          ;
        endcase
    end

    // Dwell restarts at 1 on any arrival inside, saturates while staying
    always_comb begin
        w_next_dwell = '0;
        if (w_next_state == S_INSIDE) begin
            if (r_state != S_INSIDE) begin
                w_next_dwell = DWELL_ONE;
            end else if (r_dwell != DWELL_MAX) begin
                w_next_dwell = r_dwell + DWELL_ONE;
            end else begin
                w_next_dwell = DWELL_MAX;
            end
        end
    end

    // Collect this cycle's status set requests
    always_comb begin
        w_set            = 4'b0000;
        w_set[ST_WRAP]   = w_wrap_evt;
        w_set[ST_ENTER]  = w_enter;
        w_set[ST_EXIT]   = w_exit;
        w_set[ST_CFGERR] = w_cfg_bad;
    end

    // State, bounds, dwell, sticky status and interrupt registers
    always_ff @(posedge clock) begin
        if (clear) begin
            r_state  <= S_IDLE;
            r_lo     <= '0;
            r_hi     <= '1;
            r_dwell  <= '0;
            r_status <= 4'b0000;
            r_irq    <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_dwell  <= w_next_dwell;
            // Set takes priority over acknowledge on the same bit
            r_status <= (r_status & ~irq_ack) | w_set;
            r_irq    <= |(r_status & irq_en);
            if (w_cfg_ok) begin
                r_lo <= lo_in;
                r_hi <= hi_in;
            end
        end
    end

    assign zone   = r_state;
    assign dwell  = r_dwell;
    assign status = r_status;
    assign irq    = r_irq;

endmodule

// File: tb/tb_count_window_monitor.sv
module tb_count_window_monitor;

    localparam int DW = 4;
    localparam logic [DW-1:0] DMAX = 4'hF;

    logic          clock = 1'b0;
    logic          clear = 1'b1;
    logic [7:0]    count_in = 8'h00;
    logic          load_in = 1'b0;
    logic          mode_in = 1'b0;
    logic          cfg_we = 1'b0;
    logic [7:0]    lo_in = 8'h00;
    logic [7:0]    hi_in = 8'hFF;
    logic [3:0]    irq_en = 4'h0;
    logic [3:0]    irq_ack = 4'h0;
    logic [1:0]    zone;
    logic          wrap_up;
    logic          wrap_dn;
    logic [DW-1:0] dwell;
    logic [3:0]    status;
    logic          irq;

    int total = 0;
    int bad = 0;

    // reference model state
    logic [1:0]    m_zone;
    logic          m_wu, m_wd, m_irq;
    logic [DW-1:0] m_dwell;
    logic [3:0]    m_status;
    logic [7:0]    m_lo, m_hi, m_prev;
    logic          m_has_prev, m_prev_mode, m_load_q;

    count_window_monitor #(.WIDTH(8), .DWELL_W(DW)) dut (
        .clock    (clock),
        .clear    (clear),
        .count_in (count_in),
        .load_in  (load_in),
        .mode_in  (mode_in),
        .cfg_we   (cfg_we),
        .lo_in    (lo_in),
        .hi_in    (hi_in),
        .irq_en   (irq_en),
        .irq_ack  (irq_ack),
        .zone     (zone),
        .wrap_up  (wrap_up),
        .wrap_dn  (wrap_dn),
        .dwell    (dwell),
        .status   (status),
        .irq      (irq)
    );

    // clock / reset
    always #5 clock = ~clock;

    // Behavioural model: what the monitor should report after one edge
    task automatic model_step();
        logic [1:0] z;
        logic wu, wd, en, ex;
        logic [3:0] set;
        if (clear) begin
            m_zone = 2'd0; m_wu = 1'b0; m_wd = 1'b0; m_dwell = '0;
            m_status = 4'h0; m_irq = 1'b0; m_lo = 8'h00; m_hi = 8'hFF;
            m_has_prev = 1'b0; m_load_q = 1'b0; m_prev = 8'h00; m_prev_mode = 1'b0;
        end else begin
            if (count_in < m_lo)      z = 2'd1;
            else if (count_in > m_hi) z = 2'd3;
            else                      z = 2'd2;
            wu = m_has_prev && !m_load_q && m_prev_mode && m_prev == 8'hFF && count_in == 8'h00;
            wd = m_has_prev && !m_load_q && !m_prev_mode && m_prev == 8'h00 && count_in == 8'hFF;
            en = (m_zone == 2'd1 || m_zone == 2'd3) && z == 2'd2;
            ex = (m_zone == 2'd2) && z != 2'd2;
            if (z == 2'd2) m_dwell = (m_zone != 2'd2) ? 4'd1 : ((m_dwell == DMAX) ? DMAX : m_dwell + 4'd1);
            else           m_dwell = '0;
            set = {cfg_we && (lo_in > hi_in), ex, en, wu | wd};
            m_irq = |(m_status & irq_en);
            m_status = (m_status & ~irq_ack) | set;
            if (cfg_we && lo_in <= hi_in) begin
                m_lo = lo_in;
                m_hi = hi_in;
            end
            m_zone = z; m_wu = wu; m_wd = wd;
            m_prev = count_in; m_prev_mode = mode_in; m_load_q = load_in; m_has_prev = 1'b1;
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic drive(input logic [7:0] c, input logic ld, input logic md);
        count_in = c;
        load_in  = ld;
        mode_in  = md;
        tick();
    endtask

    task automatic do_clear(input logic [7:0] c);
        clear = 1'b1;
        count_in = c;
        tick();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        do_clear(8'h00);
        total++;
        if ({zone, wrap_up, wrap_dn, dwell, status, irq} !== 13'h0) begin
            bad++;
            $display("FAIL reset: got zone=%0d wu=%0b wd=%0b dwell=%0d status=%h irq=%0b, expected all zero",
                     zone, wrap_up, wrap_dn, dwell, status, irq);
        end
    endtask

    task automatic test_window_down();
        logic [7:0] cnts [4];
        logic [1:0] exp_z [4];
        logic [DW-1:0] exp_d [4];
        cnts  = '{8'h04, 8'h03, 8'h02, 8'h01};
        exp_z = '{2'd3, 2'd2, 2'd2, 2'd1};
        exp_d = '{4'd0, 4'd1, 4'd2, 4'd0};
        cfg_we = 1'b1; lo_in = 8'h02; hi_in = 8'h03;
        drive(8'h10, 1'b1, 1'b0);
        cfg_we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(cnts[i], 1'b0, 1'b0);
            total++;
            if ({zone, dwell} !== {exp_z[i], exp_d[i]}) begin
                bad++;
                $display("FAIL window_down[%0d]: got zone=%0d dwell=%0d, expected zone=%0d dwell=%0d",
                         i, zone, dwell, exp_z[i], exp_d[i]);
            end
            total++;
            if ({zone, wrap_up, wrap_dn, dwell, status, irq} !== {m_zone, m_wu, m_wd, m_dwell, m_status, m_irq}) begin
                bad++;
                $display("FAIL window_down_model[%0d]: got %h expected %h", i,
                         {zone, wrap_up, wrap_dn, dwell, status, irq}, {m_zone, m_wu, m_wd, m_dwell, m_status, m_irq});
            end
        end
        total++;
        if (status[2:1] !== 2'b11) begin
            bad++;
            $display("FAIL window_enter_exit: got status=%b, expected enter and exit set", status);
        end
    endtask

    task automatic test_wrap_dn_irq();
        logic [7:0] cnts [5];
        cnts = '{8'h00, 8'hFF, 8'hFE, 8'hFD, 8'hFC};
        irq_en = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            irq_ack = (i == 3) ? 4'b0001 : 4'b0000;
            drive(cnts[i], 1'b0, 1'b0);
            total++;
            if ({zone, wrap_up, wrap_dn, dwell, status, irq} !== {m_zone, m_wu, m_wd, m_dwell, m_status, m_irq}) begin
                bad++;
                $display("FAIL wrap_dn_model[%0d]: got %h expected %h", i,
                         {zone, wrap_up, wrap_dn, dwell, status, irq}, {m_zone, m_wu, m_wd, m_dwell, m_status, m_irq});
            end
            if (i == 1) begin
                total++;
                if ({wrap_dn, status[0]} !== 2'b11) begin
                    bad++;
                    $display("FAIL wrap_dn_pulse: got wrap_dn=%0b wrap=%0b, expected 1 1", wrap_dn, status[0]);
                end
            end
            if (i == 2) begin
                total++;
                if ({wrap_dn, irq} !== 2'b01) begin
                    bad++;
                    $display("FAIL wrap_dn_irq: got wrap_dn=%0b irq=%0b, expected 0 1", wrap_dn, irq);
                end
            end
            if (i == 4) begin
                total++;
                if ({status[0], irq} !== 2'b00) begin
                    bad++;
                    $display("FAIL wrap_ack: got wrap=%0b irq=%0b, expected 0 0", status[0], irq);
                end
            end
        end
        irq_ack = 4'h0;
        irq_en  = 4'h0;
    endtask

    task automatic test_wrap_up_load();
        drive(8'h50, 1'b1, 1'b1);
        drive(8'hFF, 1'b0, 1'b1);
        drive(8'h00, 1'b1, 1'b0);
        total++;
        if ({wrap_up, status[0]} !== 2'b11) begin
            bad++;
            $display("FAIL wrap_up_pulse: got wrap_up=%0b wrap=%0b, expected 1 1", wrap_up, status[0]);
        end
        drive(8'hFF, 1'b0, 1'b0);
        total++;
        if ({wrap_dn, status[0]} !== 2'b01) begin
            bad++;
            $display("FAIL load_suppress: got wrap_dn=%0b wrap=%0b, expected 0 1", wrap_dn, status[0]);
        end
        total++;
        if ({zone, wrap_up, wrap_dn, dwell, status, irq} !== {m_zone, m_wu, m_wd, m_dwell, m_status, m_irq}) begin
            bad++;
            $display("FAIL wrap_up_model: got %h expected %h",
                     {zone, wrap_up, wrap_dn, dwell, status, irq}, {m_zone, m_wu, m_wd, m_dwell, m_status, m_irq});
        end
    endtask

    task automatic test_dwell_sat();
        do_clear(8'h02);
        cfg_we = 1'b1; lo_in = 8'h00; hi_in = 8'h05;
        drive(8'h02, 1'b0, 1'b1);
        cfg_we = 1'b0;
        for (int i = 0; i < 20; i++) begin
            drive(8'h02, 1'b0, 1'b1);
            total++;
            if (dwell !== m_dwell) begin
                bad++;
                $display("FAIL dwell[%0d]: got %0d expected %0d", i, dwell, m_dwell);
            end
        end
        total++;
        if (dwell !== 4'd15) begin
            bad++;
            $display("FAIL dwell_sat: got %0d expected 15", dwell);
        end
    endtask

    task automatic test_cfg_err();
        do_clear(8'h08);
        cfg_we = 1'b1; lo_in = 8'h00; hi_in = 8'h05;
        drive(8'h08, 1'b0, 1'b1);
        lo_in = 8'h10; hi_in = 8'h05;
        drive(8'h08, 1'b0, 1'b1);
        cfg_we = 1'b0;
        total++;
        if (status[3] !== 1'b1) begin
            bad++;
            $display("FAIL cfg_err_set: got %0b expected 1", status[3]);
        end
        drive(8'h08, 1'b0, 1'b1);
        total++;
        if (zone !== 2'd3) begin
            bad++;
            $display("FAIL cfg_bounds_kept: got zone=%0d expected 3", zone);
        end
        cfg_we = 1'b1; irq_ack = 4'b1000;
        drive(8'h08, 1'b0, 1'b1);
        cfg_we = 1'b0;
        total++;
        if (status[3] !== 1'b1) begin
            bad++;
            $display("FAIL cfg_set_wins: got %0b expected 1", status[3]);
        end
        drive(8'h08, 1'b0, 1'b1);
        irq_ack = 4'h0;
        total++;
        if (status[3] !== 1'b0) begin
            bad++;
            $display("FAIL cfg_ack: got %0b expected 0", status[3]);
        end
    endtask

    task automatic test_clear_mid();
        for (int i = 0; i < 3; i++) drive(8'h03, 1'b0, 1'b1);
        do_clear(8'h03);
        total++;
        if ({zone, dwell, status} !== 10'h0) begin
            bad++;
            $display("FAIL clear_mid: got zone=%0d dwell=%0d status=%h expected 0 0 0", zone, dwell, status);
        end
        drive(8'h03, 1'b0, 1'b1);
        total++;
        if ({zone, dwell, status} !== {2'd2, 4'd1, 4'h0}) begin
            bad++;
            $display("FAIL clear_first: got zone=%0d dwell=%0d status=%h expected 2 1 0", zone, dwell, status);
        end
        drive(8'h00, 1'b0, 1'b0);
        do_clear(8'h00);
        drive(8'hFF, 1'b0, 1'b0);
        total++;
        if ({wrap_dn, status} !== 5'h0) begin
            bad++;
            $display("FAIL clear_wrap: got wrap_dn=%0b status=%h expected 0 0", wrap_dn, status);
        end
    endtask

    task automatic test_random();
        logic [7:0] cnt;
        logic ld, md;
        logic [7:0] ld_val;
        cnt = 8'hFD;
        md = 1'b1;
        do_clear(8'h00);
        for (int i = 0; i < 600; i++) begin
            ld = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 15) == 0) md = ~md;
            ld_val = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
            cfg_we = ($urandom_range(0, 15) == 0);
            lo_in = 8'($urandom_range(0, 255));
            hi_in = 8'($urandom_range(0, 255));
            irq_en = 4'($urandom_range(0, 15));
            irq_ack = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            clear = ($urandom_range(0, 63) == 0);
            count_in = cnt;
            load_in = ld;
            mode_in = md;
            tick();
            total++;
            if ({zone, wrap_up, wrap_dn, dwell, status, irq} !== {m_zone, m_wu, m_wd, m_dwell, m_status, m_irq}) begin
                bad++;
                $display("FAIL random[%0d]: got %h expected %h", i,
                         {zone, wrap_up, wrap_dn, dwell, status, irq}, {m_zone, m_wu, m_wd, m_dwell, m_status, m_irq});
            end
            if (ld)      cnt = ld_val;
            else if (md) cnt = cnt + 8'd1;
            else         cnt = cnt - 8'd1;
        end
        clear = 1'b0; cfg_we = 1'b0; irq_ack = 4'h0;
    endtask

    initial begin
        test_reset();
        test_window_down();
        test_wrap_dn_irq();
        test_wrap_up_load();
        test_dwell_sat();
        test_cfg_err();
        test_clear_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
